// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I opcode, funct and operation definitions
package rv32_pkg;
  typedef logic [31:0] word_t;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
endpackage

// File: rtl/intf.sv
// intf: signal bundle around the alu
interface intf
  import rv32_pkg::*;
(
  input logic clk,
  input logic rst
);
  word_t instr;
  word_t op1;
  word_t op2;
  logic enable;
  logic instr_exec;
  word_t result;
endinterface

// File: rtl/alu_decode.sv
// alu_decode: maps an RV32I instruction word to an alu operation and a valid flag
module alu_decode
  import rv32_pkg::*;
(
  input  word_t   instr,
  output alu_op_e op,
  output logic    valid
);
  logic is_r;
  logic alt;
  logic unused;
  funct3_e f3;
  assign f3 = funct3_e'(instr[14:12]);
  assign is_r = instr[6:0] == OP_R;
  assign alt = instr[30];
  assign unused = ^{instr[24:15], instr[11:7]};
  assign valid = (is_r && (instr[31:25] == F7_BASE || instr[31:25] == F7_ALT)) || instr[6:0] == OP_I;
  always_comb begin
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/alu.sv
// alu: single-cycle RV32I integer ALU with registered result
module alu
  import rv32_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t instr,
  input  word_t op1,
  input  word_t op2,
  input  logic  enable,
  output logic  instr_exec,
  output word_t result
);
  alu_op_e op;
  logic valid;
  logic [4:0] sh;
  word_t y;
  assign sh = op2[4:0];
  alu_decode u_dec (.instr(instr), .op(op), .valid(valid));
  always_comb begin
    y = op == ALU_ADD  ? op1 + op2 :
        op == ALU_SUB  ? op1 - op2 :
        op == ALU_SLL  ? op1 << sh :
        op == ALU_SLT  ? {31'b0, $signed(op1) < $signed(op2)} :
        op == ALU_SLTU ? {31'b0, op1 < op2} :
        op == ALU_XOR  ? op1 ^ op2 :
        op == ALU_SRL  ? op1 >> sh :
        op == ALU_SRA  ? word_t'($signed(op1) >>> sh) :
        op == ALU_OR   ? op1 | op2 : op1 & op2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      instr_exec <= 1'b0;
    end else begin
      instr_exec <= enable && valid;
      if (enable && valid) result <= y;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table plus randomized checks against a reference model
module tb_alu;
  import rv32_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  intf bus (.clk(clk), .rst(rst));
  alu dut (
    .clk(clk), .rst(rst), .instr(bus.instr), .op1(bus.op1), .op2(bus.op2),
    .enable(bus.enable), .instr_exec(bus.instr_exec), .result(bus.result)
  );
  typedef struct {
    logic  r;
    logic  en;
    word_t ins;
    word_t a;
    word_t b;
    logic  exp_exec;
    word_t exp_res;
  } vec_t;
  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;
  word_t m_res;
  logic m_exec;

  function automatic word_t mk(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic vec_t v(logic r, logic en, word_t ins, word_t a, word_t b, logic ee, word_t er);
    vec_t t;
    t.r = r; t.en = en; t.ins = ins; t.a = a; t.b = b; t.exp_exec = ee; t.exp_res = er;
    return t;
  endfunction

  // Reference: {supported, value} straight from the RV32I instruction semantics
  function automatic logic [32:0] model(word_t ins, word_t a, word_t b);
    logic is_r, ok;
    int unsigned s;
    longint sa;
    word_t r;
    is_r = ins[6:0] == OP_R;
    ok = (is_r && (ins[31:25] == 7'd0 || ins[31:25] == 7'd32)) || ins[6:0] == OP_I;
    s = b % 32;
    sa = longint'(signed'(a));
    r = 0;
    case (ins[14:12])
      3'd0: r = (is_r && ins[30]) ? a - b : a + b;
      3'd1: r = a << s;
      3'd2: r = (signed'(a) < signed'(b)) ? 1 : 0;
      3'd3: r = (a < b) ? 1 : 0;
      3'd4: r = a ^ b;
      3'd5: r = ins[30] ? word_t'(sa >>> s) : a >> s;
      3'd6: r = a | b;
      3'd7: r = a & b;
      default: r = 0;
    endcase
    return {ok, r};
  endfunction

  task automatic chk(string nm, word_t act, word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic en, word_t ins, word_t a, word_t b);
    @(negedge clk);
    rst = r; bus.enable = en; bus.instr = ins; bus.op1 = a; bus.op2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] m;
    logic [6:0] opc, f7;
    rst = 1'b1; bus.enable = 1'b0; bus.instr = '0; bus.op1 = '0; bus.op2 = '0;
    vecs.push_back(v(1, 1, mk(OP_R, 3'd0, 7'd0),  32'd1, 32'd2, 0, 32'h0));
    vecs.push_back(v(0, 0, mk(OP_R, 3'd0, 7'd0),  32'd1, 32'd2, 0, 32'h0));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd0, 7'd0),  32'hFFFF_FFFF, 32'd1, 1, 32'h0));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd0, 7'd32), 32'd5, 32'd7, 1, 32'hFFFF_FFFE));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd2, 7'd0),  32'h8000_0000, 32'd1, 1, 32'd1));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd3, 7'd0),  32'h8000_0000, 32'd1, 1, 32'd0));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd5, 7'd32), 32'hF000_0000, 32'h24, 1, 32'hFF00_0000));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd5, 7'd0),  32'hF000_0000, 32'h24, 1, 32'h0F00_0000));
    vecs.push_back(v(0, 0, mk(OP_R, 3'd0, 7'd0),  32'd9, 32'd9, 0, 32'h0F00_0000));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd0, 7'd0),  32'd10, 32'd20, 1, 32'd30));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd4, 7'd0),  32'hFF, 32'h0F, 1, 32'hF0));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd6, 7'd0),  32'h100, 32'd1, 1, 32'h101));
    vecs.push_back(v(0, 0, mk(OP_R, 3'd0, 7'd0),  32'd1, 32'd1, 0, 32'h101));
    vecs.push_back(v(0, 1, mk(7'h7F, 3'd0, 7'd0), 32'd1, 32'd1, 0, 32'h101));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd0, 7'd1),  32'd1, 32'd1, 0, 32'h101));
    vecs.push_back(v(0, 1, mk(OP_R, 3'd0, 7'd0),  32'd1, 32'd1, 1, 32'd2));
    vecs.push_back(v(1, 1, mk(OP_R, 3'd0, 7'd0),  32'd5, 32'd5, 0, 32'd0));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd0, 7'd0),  32'd3, 32'd4, 1, 32'd7));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd1, 7'd0),  32'd1, 32'hFFFF_FFE1, 1, 32'd2));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd2, 7'd0),  32'hFFFF_FFFF, 32'd0, 1, 32'd1));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd3, 7'd0),  32'hFFFF_FFFF, 32'd0, 1, 32'd0));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd7, 7'd0),  32'hF0F0, 32'h0FF0, 1, 32'h00F0));
    vecs.push_back(v(0, 1, mk(OP_I, 3'd0, 7'd32), 32'd9, 32'd2, 1, 32'd11));
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].ins, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d exec", i), {31'b0, bus.instr_exec}, {31'b0, vecs[i].exp_exec});
      chk($sformatf("vec%0d result", i), bus.result, vecs[i].exp_res);
    end
    m_res = 32'h0000_000B;
    m_exec = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic r, en;
      word_t ins, a, b;
      r = $urandom_range(0, 15) == 0;
      en = $urandom_range(0, 3) != 0;
      opc = $urandom_range(0, 4) < 2 ? OP_R : ($urandom_range(0, 3) != 0 ? OP_I : 7'($urandom));
      f7 = $urandom_range(0, 5) == 0 ? 7'($urandom) : ($urandom_range(0, 1) ? 7'd32 : 7'd0);
      ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
      a = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
      b = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : $urandom;
      m = model(ins, a, b);
      if (r) begin
        m_res = 0; m_exec = 0;
      end else begin
        m_exec = en && m[32];
        if (m_exec) m_res = m[31:0];
      end
      drive(r, en, ins, a, b);
      chk($sformatf("rnd%0d exec", i), {31'b0, bus.instr_exec}, {31'b0, m_exec});
      chk($sformatf("rnd%0d result", i), bus.result, m_res);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The alu SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The alu SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The alu SHALL have port instr, input, 32 bits: RV32I instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25].
REQ-004 The alu SHALL have port op1, input, 32 bits: rs1 value.
REQ-005 The alu SHALL have port op2, input, 32 bits: rs2 value for R-type, or the upstream sign-extended immediate for I-type.
REQ-006 The alu SHALL have port enable, input, 1 bit: instr/op1/op2 are valid this cycle.
REQ-007 The alu SHALL have port instr_exec, output, 1 bit: a result was produced at the last edge.
REQ-008 The alu SHALL have port result, output, 32 bits: registered ALU result.
REQ-009 The alu SHALL use one clock, with reset synchronous and active-high; the ports SHALL be named clk and rst.

Function
REQ-010 The alu SHALL accept an instruction on a rising edge when enable=1 and rst=0, with no backpressure and one instruction per cycle.
REQ-011 The alu SHALL have a latency of 1 cycle: result and instr_exec SHALL be registered and visible after the accepting edge.
REQ-012 The alu SHALL drive instr_exec=1 for exactly one cycle per accepted supported instruction; back-to-back enables SHALL keep it high continuously.
REQ-013 When enable=0, the alu SHALL drive instr_exec=0 and SHALL hold result at its last value.
REQ-014 The alu SHALL support opcode 0110011 (R-type): ADD/SUB (funct7[5] selects SUB), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5] selects SRA), OR, AND.
REQ-015 The alu SHALL support opcode 0010011 (I-type): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (instr[30] selects SRAI); there SHALL be no SUBI.
REQ-016 The alu SHALL use op2[4:0] as the shift amount; upper bits SHALL be ignored.
REQ-017 The alu SHALL perform add/sub modulo 2^32, with overflow and carry discarded and no flags.
REQ-018 SLT/SLTI SHALL compare signed and SLTU/SLTIU SHALL compare unsigned; the result SHALL be 32'd1 or 32'd0.
REQ-019 SRA/SRAI SHALL replicate op1[31].
REQ-020 On an unsupported opcode, or an R-type funct7 other than 0000000/0100000, the alu SHALL set instr_exec=0 and hold result.
REQ-021 The alu SHALL be purely combinational from inputs to the next-state logic, with no internal pipeline beyond the output registers.

Reset
REQ-022 While rst=1 at a rising edge, the alu SHALL set result=32'h0 and instr_exec=0.
REQ-023 rst SHALL take priority over enable; an instruction presented during reset SHALL be dropped and not executed later.
REQ-024 Reset asserted mid-stream SHALL clear the outputs on the next edge; the first enable after deassertion SHALL execute normally.

Structure
REQ-025 A shared package rv32_pkg SHALL hold the opcode constants (OP_R=7'b0110011, OP_I=7'b0010011), the funct3 codes as an enum, the funct7 constants, and a 32-bit word typedef.
REQ-026 The companion interface intf(clk, rst) SHALL bundle instr, op1, op2, enable, instr_exec and result for the bench.
REQ-027 The design SHALL contain one sub-module, alu_decode (combinational: instr -> operation enum + valid flag); alu SHALL instantiate it and own the datapath and registers.

Verification
REQ-028 Reset check: rst=1 for one edge with enable=1 -> result=0 and instr_exec=0; after release with enable=0, outputs SHALL stay 0.
REQ-029 ADD/SUB: R-type ADD with op1=32'hFFFF_FFFF, op2=1 -> result=0 and instr_exec=1 next cycle; SUB with op1=5, op2=7 -> result=32'hFFFF_FFFE.
REQ-030 SLT vs SLTU: op1=32'h8000_0000, op2=1 -> SLT=1, SLTU=0.
REQ-031 Shifts: SRA with op1=32'hF000_0000, op2=32'h24 -> result=32'hFF00_0000 (shamt=4); SRLI, same operands -> result=32'h0F00_0000.
REQ-032 Handshake: three back-to-back enables followed by enable=0 -> instr_exec high for 3 cycles then low, with result holding the third value; an illegal opcode 7'b1111111 -> instr_exec=0 and result unchanged.
REQ-033 Mid-stream reset: assert rst during a burst -> outputs zero on the next edge, and the first post-reset ADDI with op1=3, op2=4 -> result=7.
